// File: rtl/packet_analyzer_stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_pkg: shared state encoding, frame constants and helpers. Rev 1.0
// ----------------------------------------------------------------------------
package node_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DST   = 3'd1,
    ST_SRC   = 3'd2,
    ST_TYPE  = 3'd3,
    ST_TS    = 3'd4,
    ST_SEQ   = 3'd5,
    ST_SEND  = 3'd6,
    ST_DRAIN = 3'd7
  } state_t;

  localparam logic [15:0] ETHERNET_TYPE_REPLY = 16'h88B5;
  localparam logic [47:0] BROADCAST_MAC       = 48'hFFFF_FFFF_FFFF;

  localparam int STAT_GAP     = 0;
  localparam int STAT_REORDER = 1;
  localparam int STAT_FIRST   = 2;

  function automatic int REC_BYTES(input int ts_w, input int seq_w);
`ifdef LATENCY_SEQ_CHECK_EN
    return ts_w / 8 + seq_w / 8 + 2;
`else
    return ts_w / 8 + seq_w / 8 + 1;
`endif
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [63:0] b);
    logic [63:0] room;
    room = 64'(16'hFFFF - a);
    return (b > room) ? 16'hFFFF : a + b[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_analyzer_stream_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// packet_analyzer_stream_if: receive-FIFO and transmit-byte stream bundle. Rev 1.0
// ----------------------------------------------------------------------------
interface packet_analyzer_stream_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_read;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_empty, tx_ready, input rx_read, tx_data, tx_valid);
  modport slave  (input rx_data, rx_empty, tx_ready, output rx_read, tx_data, tx_valid);
endinterface
`default_nettype wire

// File: rtl/packet_analyzer_stream_record_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// record_serializer: shifts a latched record out MSB byte first over valid/ready. Rev 1.0
// ----------------------------------------------------------------------------
module record_serializer
  import node_pkg::*;
#(
  parameter int REC_N = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [REC_N*8-1:0] record,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               done
);
  localparam int CW = $clog2(REC_N + 1);

  logic [REC_N*8-1:0] shreg;
  logic [CW-1:0]      remaining;

  assign tx_data = shreg[REC_N*8-1 -: 8];
  assign done    = tx_valid && tx_ready && (remaining == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      remaining <= '0;
      tx_valid  <= 1'b0;
    end else if (start) begin
      shreg     <= record;
      remaining <= CW'(REC_N - 1);
      tx_valid  <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (remaining == '0) begin
        tx_valid <= 1'b0;
      end else begin
        shreg     <= shreg << 8;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_analyzer_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// packet_analyzer_stream: parses reply frames from an FWFT FIFO and streams latency
// records. Macro LATENCY_SEQ_CHECK_EN adds sequence tracking + status byte. Rev 1.0
// ----------------------------------------------------------------------------
module packet_analyzer_stream
  import node_pkg::*;
#(
  parameter int TS_W        = 32,
  parameter int SEQ_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TS_W-1:0]         global_timer,
  input  logic [47:0]             mac_address,
  packet_analyzer_stream_if.slave bus,
  output logic [15:0]             frames_ok,
  output logic [15:0]             frames_dropped,
  output logic [15:0]             lost_count
);
  localparam int         TS_BYTES  = TS_W / 8;
  localparam int         SEQ_BYTES = SEQ_W / 8;
  localparam int         REC_N     = REC_BYTES(TS_W, SEQ_W);
  localparam int         TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] ADDR_LAST = 3'd5;
  localparam logic [2:0] TYPE_LAST = 3'd1;
  localparam logic [2:0] TS_LAST   = 3'(TS_BYTES - 1);
  localparam logic [2:0] SEQ_LAST  = 3'(SEQ_BYTES - 1);

  state_t             state;
  logic [2:0]         cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [47:0]        dst;
  logic [7:0]         src_byte;
  logic [15:0]        type_reg;
  logic [TS_W-1:0]    ts_reg;
  logic [TS_W-1:0]    arrival;
  logic [SEQ_W-1:0]   seq_reg;

  logic               in_frame;
  logic               abort;
  logic               timeout;
  logic               start;
  logic               done;
  logic [TS_W-1:0]    ts_next;
  logic [SEQ_W-1:0]   seq_full;
  logic [TS_W-1:0]    latency;
  logic [REC_N*8-1:0] record;

  assign bus.rx_read = !bus.rx_empty &&
                       (state inside {ST_DST, ST_SRC, ST_TYPE, ST_TS, ST_SEQ, ST_DRAIN});

  assign in_frame = state inside {ST_DST, ST_SRC, ST_TYPE, ST_TS, ST_SEQ};
  // Filters are evaluated on the first cycle of the state following the field.
  assign abort    = ((state == ST_SRC) && (dst != mac_address) && (dst != BROADCAST_MAC)) ||
                    ((state == ST_TS) && (type_reg != ETHERNET_TYPE_REPLY));
  assign timeout  = in_frame && !abort && bus.rx_empty &&
                    (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  assign ts_next  = TS_W'({ts_reg, bus.rx_data});
  assign seq_full = SEQ_W'({seq_reg, bus.rx_data});
  assign latency  = arrival - ts_reg;
  assign start    = (state == ST_SEQ) && bus.rx_read && (cnt == SEQ_LAST);

`ifdef LATENCY_SEQ_CHECK_EN
  logic [SEQ_W-1:0] exp_seq;
  logic             exp_valid;
  logic [SEQ_W-1:0] seq_diff;
  logic [7:0]       status;

  assign seq_diff = seq_full - exp_seq;

  always_comb begin
    status               = '0;
    status[STAT_FIRST]   = !exp_valid;
    status[STAT_REORDER] = exp_valid && seq_diff[SEQ_W-1];
    status[STAT_GAP]     = exp_valid && !seq_diff[SEQ_W-1] && (seq_diff != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_seq    <= '0;
      exp_valid  <= 1'b0;
      lost_count <= '0;
    end else if (start) begin
      exp_seq   <= seq_full + 1'b1;
      exp_valid <= 1'b1;
      if (status[STAT_GAP])
        lost_count <= sat_add16(lost_count, 64'(seq_diff));
    end
  end

  assign record = {latency, seq_full, src_byte, status};
`else
  assign lost_count = '0;
  assign record     = {latency, seq_full, src_byte};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      to_cnt         <= '0;
      dst            <= '0;
      src_byte       <= '0;
      type_reg       <= '0;
      ts_reg         <= '0;
      arrival        <= '0;
      seq_reg        <= '0;
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.rx_empty) begin
            arrival <= global_timer;
            state   <= ST_DST;
            cnt     <= '0;
            to_cnt  <= '0;
          end
        end
        ST_DST, ST_SRC, ST_TYPE, ST_TS, ST_SEQ: begin
          // abort and timeout are exclusive, so a drop is counted once per frame.
          if (abort || timeout) begin
            state          <= abort ? ST_DRAIN : ST_IDLE;
            frames_dropped <= sat_inc16(frames_dropped);
            to_cnt         <= '0;
          end else if (bus.rx_empty) begin
            to_cnt <= to_cnt + 1'b1;
          end else begin
            to_cnt <= '0;
            cnt    <= cnt + 3'd1;
            case (state)
              ST_DST: begin
                dst <= {dst[39:0], bus.rx_data};
                if (cnt == ADDR_LAST) begin
                  state <= ST_SRC;
                  cnt   <= '0;
                end
              end
              ST_SRC: begin
                src_byte <= bus.rx_data;
                if (cnt == ADDR_LAST) begin
                  state <= ST_TYPE;
                  cnt   <= '0;
                end
              end
              ST_TYPE: begin
                type_reg <= {type_reg[7:0], bus.rx_data};
                if (cnt == TYPE_LAST) begin
                  state <= ST_TS;
                  cnt   <= '0;
                end
              end
              ST_TS: begin
                ts_reg <= ts_next;
                if (cnt == TS_LAST) begin
                  state <= ST_SEQ;
                  cnt   <= '0;
                end
              end
              ST_SEQ: begin
                seq_reg <= seq_full;
                if (cnt == SEQ_LAST) begin
                  state <= ST_SEND;
                  cnt   <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_SEND: begin
          if (done) begin
            state     <= ST_DRAIN;
            frames_ok <= sat_inc16(frames_ok);
          end
        end
        ST_DRAIN: begin
          if (bus.rx_empty)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  record_serializer #(
    .REC_N (REC_N)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .record   (record),
    .tx_ready (bus.tx_ready),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .done     (done)
  );

endmodule
`default_nettype wire

// File: tb/tb_packet_analyzer_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_packet_analyzer_stream: FIFO-fed scoreboard bench for packet_analyzer_stream. Rev 1.0
// ----------------------------------------------------------------------------
module tb_packet_analyzer_stream;
  import node_pkg::*;

  localparam int TS_W        = 32;
  localparam int SEQ_W       = 32;
  localparam int TIMEOUT_CYC = 4;
  localparam int REC_N       = REC_BYTES(TS_W, SEQ_W);
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_07;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gtimer = '0;
  logic [15:0] frames_ok, frames_dropped, lost_count;

  packet_analyzer_stream_if bus();

  packet_analyzer_stream #(
    .TS_W        (TS_W),
    .SEQ_W       (SEQ_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .global_timer   (gtimer),
    .mac_address    (MAC),
    .bus            (bus),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped),
    .lost_count     (lost_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         hs_cnt = 0;
  int         hold_cnt = 0;
  int         ready_mode = 1;   // 0 low, 1 high, 2 toggle each cycle
  logic       rd_q = 1'b0;
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  logic       held_v = 1'b0;
  logic [7:0] held;
  logic       m_valid = 1'b0;
  logic [31:0] m_exp = '0;

  // FIFO model: pop what the DUT read last cycle, then present the new head.
  always @(posedge clk) begin
    if (rd_q && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    bus.rx_empty = (fifo.size() == 0);
    bus.rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    case (ready_mode)
      0:       bus.tx_ready = 1'b0;
      1:       bus.tx_ready = 1'b1;
      default: bus.tx_ready = (bus.tx_ready === 1'b1) ? 1'b0 : 1'b1;
    endcase
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    rd_q = bus.rx_read;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        hold_cnt++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) begin
          errors++;
          $display("FAIL hold: valid=%b data=%02h, required valid=1 data=%02h",
                   bus.tx_valid, bus.tx_data, held);
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        checks++;
        hs_cnt++;
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL record_byte: got %02h, required no output", bus.tx_data);
        end else begin
          held = exp_q.pop_front();
          if (bus.tx_data !== held) begin
            errors++;
            $display("FAIL record_byte: got %02h, required %02h", bus.tx_data, held);
          end
        end
      end else if (bus.tx_valid === 1'b1) begin
        held_v = 1'b1;
        held   = bus.tx_data;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic push_frame(input logic [47:0] dst, input logic [7:0] srcl,
                            input logic [15:0] typ, input logic [31:0] ts,
                            input logic [31:0] seq, input int nb, input bit good);
    logic [7:0]  b[$];
    logic [31:0] lat;
    logic [31:0] d;
    logic [7:0]  st;
    for (int i = 5; i >= 0; i--) b.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < 5; i++) b.push_back(8'hA0 + 8'(i));
    b.push_back(srcl);
    b.push_back(typ[15:8]);
    b.push_back(typ[7:0]);
    for (int i = 3; i >= 0; i--) b.push_back(ts[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(seq[i*8 +: 8]);
    if (good) begin
      lat = gtimer - ts;
      for (int i = 3; i >= 0; i--) exp_q.push_back(lat[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(seq[i*8 +: 8]);
      exp_q.push_back(srcl);
`ifdef LATENCY_SEQ_CHECK_EN
      st = 8'h00;
      if (!m_valid) st[2] = 1'b1;
      else begin
        d = seq - m_exp;
        if (d[31]) st[1] = 1'b1;
        else if (d != 0) st[0] = 1'b1;
      end
      m_exp   = seq + 32'd1;
      m_valid = 1'b1;
      exp_q.push_back(st);
`else
      d  = '0;
      st = '0;
`endif
    end
    for (int i = 0; i < nb; i++) fifo.push_back(b[i]);
  endtask

  task automatic wait_quiet(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fifo.size() == 0 && exp_q.size() == 0 && bus.tx_valid === 1'b0 && bus.rx_empty === 1'b1)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_read !== 1'b0) begin errors++; $display("FAIL reset_rx_read: got %b, required 0", bus.rx_read); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", bus.tx_data); end
    checks++; if (frames_ok !== 16'd0) begin errors++; $display("FAIL reset_frames_ok: got %0d, required 0", frames_ok); end
    checks++; if (frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_frames_dropped: got %0d, required 0", frames_dropped); end
    checks++; if (lost_count !== 16'd0) begin errors++; $display("FAIL reset_lost_count: got %0d, required 0", lost_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    gtimer = 32'h0000_0164;
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'h0000_0100, 32'd5, 22, 1'b1);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got stuck, required idle"); end
    checks++; if (frames_ok !== 16'd1) begin errors++; $display("FAIL basic_frames_ok: got %0d, required 1", frames_ok); end
    checks++; if (frames_dropped !== 16'd0) begin errors++; $display("FAIL basic_dropped: got %0d, required 0", frames_dropped); end
  endtask

  task automatic test_drop;
    bit ok;
    int hs0 = hs_cnt;
    gtimer = 32'h0000_0200;
    push_frame(BROADCAST_MAC, 8'h33, 16'h0800, 32'h1, 32'h9, 22, 1'b0);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_type_drain: got stuck, required idle"); end
    checks++; if (frames_dropped !== 16'd1) begin errors++; $display("FAIL drop_type_count: got %0d, required 1", frames_dropped); end
    checks++; if (bus.rx_read !== 1'b0) begin errors++; $display("FAIL drop_type_rx_read: got %b, required 0", bus.rx_read); end
    push_frame(48'h02_00_00_00_00_99, 8'h44, ETHERNET_TYPE_REPLY, 32'h1, 32'h9, 22, 1'b0);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_dst_drain: got stuck, required idle"); end
    checks++; if (frames_dropped !== 16'd2) begin errors++; $display("FAIL drop_dst_count: got %0d, required 2", frames_dropped); end
    checks++; if (hs_cnt != hs0 || frames_ok !== 16'd1) begin
      errors++; $display("FAIL drop_no_output: got %0d bytes ok=%0d, required 0 bytes ok=1", hs_cnt - hs0, frames_ok);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    gtimer = 32'h0000_0010;
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'hFFFF_FFF0, 32'd6, 22, 1'b1);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got stuck, required idle"); end
    checks++; if (frames_ok !== 16'd2) begin errors++; $display("FAIL wrap_frames_ok: got %0d, required 2", frames_ok); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int hs0 = hs_cnt;
    int hold0 = hold_cnt;
    gtimer = 32'h1122_3344;
    ready_mode = 2;
    push_frame(BROADCAST_MAC, 8'h99, ETHERNET_TYPE_REPLY, 32'h0, 32'h5566_7788, 22, 1'b1);
    wait_quiet(ok);
    ready_mode = 1;
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done: got stuck, required idle"); end
    checks++; if (hs_cnt - hs0 != REC_N) begin errors++; $display("FAIL bp_byte_count: got %0d, required %0d", hs_cnt - hs0, REC_N); end
    checks++; if (hold_cnt == hold0) begin errors++; $display("FAIL bp_stalls: got 0 stall cycles, required >0"); end
    checks++; if (frames_ok !== 16'd3) begin errors++; $display("FAIL bp_frames_ok: got %0d, required 3", frames_ok); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n = 0;
    logic [15:0] d0 = frames_dropped;
    gtimer = 32'h0000_0500;
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'h0000_0400, 32'd7, 20, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frames_dropped != d0) break;
      if (fifo.size() == 0 && bus.rx_empty === 1'b1) n++;
    end
    checks++; if (frames_dropped !== d0 + 16'd1) begin errors++; $display("FAIL timeout_count: got %0d, required %0d", frames_dropped, d0 + 16'd1); end
    checks++; if (n != TIMEOUT_CYC) begin errors++; $display("FAIL timeout_cycles: got %0d, required %0d", n, TIMEOUT_CYC); end
    gtimer = 32'h0000_0900;
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'h0000_0880, 32'd7, 22, 1'b1);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_next_done: got stuck, required idle"); end
    checks++; if (frames_ok !== 16'd4) begin errors++; $display("FAIL timeout_next_ok: got %0d, required 4", frames_ok); end
  endtask

`ifdef LATENCY_SEQ_CHECK_EN
  task automatic test_seq_check;
    bit ok;
    @(negedge clk);
    rst_n = 1'b0;
    m_valid = 1'b0;
    m_exp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gtimer = 32'h0000_1000;
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'h0000_0F00, 32'd1, 22, 1'b1);
    wait_quiet(ok);
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'h0000_0F00, 32'd2, 22, 1'b1);
    wait_quiet(ok);
    push_frame(MAC, 8'h07, ETHERNET_TYPE_REPLY, 32'h0000_0F00, 32'd5, 22, 1'b1);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_done: got stuck, required idle"); end
    checks++; if (lost_count !== 16'd2) begin errors++; $display("FAIL seq_lost: got %0d, required 2", lost_count); end
    checks++; if (frames_ok !== 16'd3) begin errors++; $display("FAIL seq_frames_ok: got %0d, required 3", frames_ok); end
  endtask
`else
  task automatic test_seq_check;
    checks++; if (lost_count !== 16'd0) begin errors++; $display("FAIL lost_tied: got %0d, required 0", lost_count); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_seq_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packet_analyzer_stream.md
# packet_analyzer_stream

Parametrised successor to the measurer-node Ethernet packet analyser. It parses reply frames from the receive FIFO and computes latency against the global timer. Each valid measurement is emitted as a byte record over a valid/ready stream toward the UART. Over its predecessor it adds configurable widths, truncated-frame timeout, a backpressured output, saturating frame statistics and optional sequence-gap detection.

## Interface
Parameters:
- TS_W, 32: timestamp/latency width in bits. Must be a multiple of 8, range 8..64.
- SEQ_W, 32: sequence-number width in bits. Must be a multiple of 8, range 8..64.
- TIMEOUT_CYC, 255: consecutive empty cycles mid-frame before the frame is abandoned. Must be ≥1.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- global_timer, in, TS_W: free-running time counter.
- mac_address, in, 48: node MAC address.
- rx_data, in, 8: FIFO head byte. First-word-fall-through; valid while rx_empty=0.
- rx_empty, in, 1: FIFO empty.
- rx_read, out, 1: pops the head byte this cycle.
- tx_data, out, 8: record byte.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: sink accepts the byte.
- frames_ok, out, 16: measurements emitted. Saturating.
- frames_dropped, out, 16: frames dropped for address mismatch, type mismatch or timeout. Saturating.
- lost_count, out, 16: sequence numbers skipped. Saturating. Tied to 0 when LATENCY_SEQ_CHECK_EN is undefined.

## Operation
- Frame boundaries are marked by the FIFO going empty: a frame begins on the first non-empty cycle after IDLE.
- States and transitions:
  - IDLE → DST when !rx_empty. Arrival time is latched from global_timer on that same cycle.
  - DST (6 bytes) → SRC. From SRC onward, if dst ≠ mac_address and dst ≠ FF:FF:FF:FF:FF:FF → DRAIN, drop counted.
  - SRC (6 bytes; only the last byte is kept) → TYPE.
  - TYPE (2 bytes) → TS. If type ≠ ETHERNET_TYPE_REPLY → DRAIN, drop counted.
  - TS (TS_W/8 bytes) → SEQ (SEQ_W/8 bytes) → SEND.
  - SEND → DRAIN after the last record byte handshake; frames_ok increments.
  - DRAIN → IDLE when rx_empty.
- Byte consumption:
  - rx_read = !rx_empty in DST/SRC/TYPE/TS/SEQ/DRAIN; rx_read = 0 in IDLE and SEND.
  - Byte counters advance only on consumed bytes, never on stall cycles.
- Timeout: in DST..SEQ, TIMEOUT_CYC consecutive cycles with rx_empty=1 → IDLE, drop counted. A consumed byte resets the timeout count.
- Latency = arrival − packet timestamp, modulo 2^TS_W; wrap-around gives the correct unsigned difference.
- Record bytes, each field MSB first:
  - latency (TS_W/8 bytes)
  - sequence (SEQ_W/8 bytes)
  - src byte (1 byte)
  - status byte (1 byte, only with the macro)
- Multi-byte fields shift in MSB first.
- Counters hold at 16'hFFFF.

## Timing
- Reset values: every output is 0, state is IDLE, and all internal registers are 0.
- Reset asserted mid-frame aborts immediately, with no counter update. Bytes left in the FIFO are then parsed as a new frame.
- rx_read is combinational from the state register and rx_empty.
- tx_valid, tx_data and the counters are registered.
- tx_valid rises on the cycle after the last SEQ byte is consumed.
- A record byte advances only on tx_valid && tx_ready. tx_data is held stable while tx_valid=1 && tx_ready=0.
- With continuous ready, the record is emitted in TS_W/8 + SEQ_W/8 + 1 (+1) consecutive cycles.
- When a drop and a timeout coincide on the same cycle, frames_dropped increments exactly once.

## Configuration
- LATENCY_SEQ_CHECK_EN defined:
  - Tracks an expected sequence number (expected = seq+1 after each emitted record) plus a valid flag; the flag is cleared by reset.
  - Status byte: bit0 = gap (seq > expected), bit1 = reorder/duplicate (seq − expected has its MSB set or is behind), bit2 = first frame since reset. Remaining bits are 0.
  - On a gap, lost_count += seq − expected, saturating.
- LATENCY_SEQ_CHECK_EN undefined: no status byte, no tracking logic, lost_count = 0.

## Structure
- Package node_pkg holds:
  - the state encoding
  - ETHERNET_TYPE_REPLY (16-bit constant)
  - the broadcast MAC constant
  - record-length function REC_BYTES(TS_W, SEQ_W)
  - status-bit indices
- Sub-module record_serializer: takes the latched record fields and a start pulse, produces tx_data/tx_valid with tx_ready backpressure, and returns a done pulse.

## Test plan
- Frame to mac_address 02:00:00:00:00:07, src last byte 0x07, type REPLY, TS 0x00000100, seq 5; arrival 0x00000164; tx_ready=1 → record 00 00 00 64 00 00 00 05 07; frames_ok=1.
- Broadcast frame with type 0x0800 → no tx_valid; all bytes drained; frames_dropped=1; returns to IDLE.
- Packet timestamp 0xFFFFFFF0, arrival 0x00000010 → latency bytes 00 00 00 20.
- tx_ready toggled 0/1 every cycle → each byte held while ready is low; nine distinct bytes emitted in order, with no loss or duplication.
- FIFO goes empty after 20 bytes with TIMEOUT_CYC=4 → back to IDLE after 4 idle cycles; frames_dropped=1; a following good frame is parsed correctly.
- With LATENCY_SEQ_CHECK_EN: seq 1, 2, then 5 → status bytes 0x04, 0x00, 0x01; lost_count=2.
